// File: rtl/bcd_bin_conv_n.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Non-decimal digits are flagged through err and skip the shifting phase.
module bcd_bin_conv_n #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BW     = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BW-1:0]         bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic                  err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BW + 1);

  typedef enum logic [1:0] {StIdle, StOp, StDone} state_t;

  state_t            state_q, state_d;
  logic [BcdW-1:0]   b_q, b_d;
  logic [BW-1:0]     a_q, a_d;
  logic [CntW-1:0]   n_q, n_d;
  logic [BW-1:0]     bin_q, bin_d;
  logic              err_q, err_d;

  logic              bad_digit;
  logic [BcdW-1:0]   b_raw, b_fix;
  logic [BW-1:0]     a_shift;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shift {b,a} right, then pull every BCD digit of value 8..15 back by 3.
  always_comb begin
    b_raw   = b_q >> 1;
    a_shift = {b_q[0], a_q[BW-1:1]};
    b_fix   = b_raw;
    for (int i = 0; i < DIGITS; i++) begin
      if (b_raw[4*i+3]) b_fix[4*i +: 4] = b_raw[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    a_d     = a_q;
    n_d     = n_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          b_d = bcd;
          a_d = '0;
          n_d = CntW'(BW);
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StOp;
          end
        end
      end
      StOp: begin
        b_d = b_fix;
        a_d = a_shift;
        n_d = n_q - CntW'(1);
        if (n_q == CntW'(1)) begin
          bin_d   = a_shift;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      b_q     <= '0;
      a_q     <= '0;
      n_q     <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      a_q     <= a_d;
      n_q     <= n_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bin       = bin_q;
  assign err       = err_q;
  assign ready     = (state_q == StIdle);
  assign done_tick = (state_q == StDone);

endmodule
